// File: rtl/alu_issue_stage.sv
// ALU issue/EX stage: decodes the ALU command, holds the EX pipeline register,
// forwards operands from MEM/WB and resolves BEQ/BNE from the ALU zero flag.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            op5,
    input  logic            is_branch,
    input  logic            alusrc,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic [XLEN-1:0] imm,
    input  logic            mem_regwrite,
    input  logic            wb_regwrite,
    input  logic [4:0]      mem_rd,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] wb_result,
    input  logic [XLEN-1:0] alu_result,
    input  logic            zero,
    output logic            ex_valid,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] srca,
    output logic [XLEN-1:0] srcb,
    output logic [4:0]      ex_rd,
    output logic            illegal,
    output logic            branch_taken
);

    typedef struct packed {
        logic            valid;
        logic [3:0]      alu_control;
        logic            illegal;
        logic            is_branch;
        logic            funct3_0;
        logic            alusrc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
    } ex_reg_t;

    localparam ex_reg_t BUBBLE = '0;

    ex_reg_t   ex_q, ex_d;
    logic [3:0] dec_ctrl;
    logic       dec_illegal;

    // ALU result is produced downstream of this stage; only observed here.
    logic unused_alu_result;
    assign unused_alu_result = ^alu_result;

    always_comb begin
        dec_ctrl    = 4'b0000;
        dec_illegal = 1'b0;
        unique case (alu_op)
            2'b00: dec_ctrl = 4'b0000;
            2'b01: dec_ctrl = 4'b0001;
            2'b10: begin
                unique case (funct3)
                    3'b000:  dec_ctrl = (op5 & funct7b5) ? 4'b0001 : 4'b0000;
                    3'b010:  dec_ctrl = 4'b0101;
                    3'b100:  dec_ctrl = 4'b0100;
                    3'b110:  dec_ctrl = 4'b0011;
                    3'b111:  dec_ctrl = 4'b0010;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Priority: flush beats stall beats load; reset handled in the register.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = BUBBLE;
        end else if (!stall) begin
            if (in_valid) begin
                ex_d.valid       = 1'b1;
                ex_d.alu_control = dec_ctrl;
                ex_d.illegal     = dec_illegal;
                ex_d.is_branch   = is_branch;
                ex_d.funct3_0    = funct3[0];
                ex_d.alusrc      = alusrc;
                ex_d.rs1         = rs1;
                ex_d.rs2         = rs2;
                ex_d.rd          = rd;
                ex_d.rd1         = rd1;
                ex_d.rd2         = rd2;
                ex_d.imm         = imm;
            end else begin
                ex_d = BUBBLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= BUBBLE;
        else     ex_q <= ex_d;
    end

    // MEM is younger than WB, so it wins; x0 is never forwarded.
    logic [XLEN-1:0] fwd_a, fwd_b;

    always_comb begin
        fwd_a = ex_q.rd1;
        if (mem_regwrite && mem_rd == ex_q.rs1 && ex_q.rs1 != 5'd0)
            fwd_a = mem_result;
        else if (wb_regwrite && wb_rd == ex_q.rs1 && ex_q.rs1 != 5'd0)
            fwd_a = wb_result;
    end

    always_comb begin
        fwd_b = ex_q.rd2;
        if (mem_regwrite && mem_rd == ex_q.rs2 && ex_q.rs2 != 5'd0)
            fwd_b = mem_result;
        else if (wb_regwrite && wb_rd == ex_q.rs2 && ex_q.rs2 != 5'd0)
            fwd_b = wb_result;
    end

    assign ex_valid     = ex_q.valid;
    assign alu_control  = ex_q.alu_control;
    assign srca         = fwd_a;
    assign srcb         = ex_q.alusrc ? ex_q.imm : fwd_b;
    assign ex_rd        = ex_q.rd;
    assign illegal      = ex_q.illegal & ex_q.valid;
    // funct3[0] distinguishes BNE (1) from BEQ (0).
    assign branch_taken = ex_q.valid & ex_q.is_branch & (zero ^ ex_q.funct3_0);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: one task per feature, inline checks.
module tb_alu_issue_stage;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, in_valid, stall, flush;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7b5, op5, is_branch, alusrc;
    logic [4:0]      rs1, rs2, rd, mem_rd, wb_rd;
    logic [XLEN-1:0] rd1, rd2, imm, mem_result, wb_result, alu_result;
    logic            mem_regwrite, wb_regwrite, zero;
    logic            ex_valid, illegal, branch_taken;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] srca, srcb;
    logic [4:0]      ex_rd;

    int errors = 0;
    int checks = 0;

    alu_issue_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5), .op5(op5),
        .is_branch(is_branch), .alusrc(alusrc), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rd1(rd1), .rd2(rd2), .imm(imm), .mem_regwrite(mem_regwrite),
        .wb_regwrite(wb_regwrite), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_result(mem_result), .wb_result(wb_result), .alu_result(alu_result),
        .zero(zero), .ex_valid(ex_valid), .alu_control(alu_control),
        .srca(srca), .srcb(srcb), .ex_rd(ex_rd), .illegal(illegal),
        .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; in_valid = 0; stall = 0; flush = 0;
        alu_op = 2'b00; funct3 = 3'b000; funct7b5 = 0; op5 = 0;
        is_branch = 0; alusrc = 0; rs1 = 0; rs2 = 0; rd = 0;
        rd1 = 0; rd2 = 0; imm = 0;
        mem_regwrite = 0; wb_regwrite = 0; mem_rd = 0; wb_rd = 0;
        mem_result = 0; wb_result = 0; alu_result = 0; zero = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rd1 = 32'hdead; rd2 = 32'hbeef; rd = 5'd7; in_valid = 1;
        rst = 1;
        step();
        rst = 0; in_valid = 0;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", ex_valid); end
        checks++; if (alu_control !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%0h exp=0", alu_control); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0h exp=0", ex_rd); end
        checks++; if (illegal !== 1'b0 || branch_taken !== 1'b0) begin errors++; $display("FAIL reset_flags got=%0b%0b exp=00", illegal, branch_taken); end
        checks++; if (srca !== 0 || srcb !== 0) begin errors++; $display("FAIL reset_src got=%0h/%0h exp=0/0", srca, srcb); end
    endtask

    task automatic test_rtype_sub();
        idle_inputs();
        in_valid = 1; alu_op = 2'b10; funct3 = 3'b000; op5 = 1; funct7b5 = 1;
        rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; rd1 = 32'd9; rd2 = 32'd4;
        step();
        checks++; if (alu_control !== 4'b0001) begin errors++; $display("FAIL sub_ctrl got=%0h exp=1", alu_control); end
        checks++; if (srca !== 32'd9) begin errors++; $display("FAIL sub_srca got=%0h exp=9", srca); end
        checks++; if (srcb !== 32'd4) begin errors++; $display("FAIL sub_srcb got=%0h exp=4", srcb); end
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3) begin errors++; $display("FAIL sub_valid_rd got=%0h/%0h exp=1/3", ex_valid, ex_rd); end
    endtask

    task automatic test_decode();
        logic [2:0] f3_tab [6] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111, 3'b000};
        logic       o5_tab [6] = '{1'b0,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1};
        logic [3:0] exp_tab[6] = '{4'b0000, 4'b0101, 4'b0100, 4'b0011, 4'b0010, 4'b0000};
        idle_inputs();
        in_valid = 1; alu_op = 2'b10; funct7b5 = 1;
        for (int i = 0; i < 6; i++) begin
            funct3 = f3_tab[i]; op5 = o5_tab[i];
            if (i == 5) funct7b5 = 0;
            step();
            checks++; if (alu_control !== exp_tab[i] || illegal !== 1'b0) begin errors++; $display("FAIL decode_%0d got=%0h/%0b exp=%0h/0", i, alu_control, illegal, exp_tab[i]); end
        end
        // add for ld/st with immediate operand
        alu_op = 2'b00; funct3 = 3'b010; alusrc = 1; imm = 32'hffff_fff8; rd2 = 32'h55;
        step();
        checks++; if (alu_control !== 4'b0000 || srcb !== 32'hffff_fff8) begin errors++; $display("FAIL decode_ldst got=%0h/%0h exp=0/fffffff8", alu_control, srcb); end
    endtask

    task automatic test_forwarding();
        idle_inputs();
        in_valid = 1; alu_op = 2'b00; rs1 = 5'd5; rs2 = 5'd5; rd1 = 32'h33; rd2 = 32'h44;
        step();
        in_valid = 0; stall = 1;
        mem_regwrite = 1; mem_rd = 5'd5; mem_result = 32'h11;
        wb_regwrite = 1;  wb_rd = 5'd5;  wb_result = 32'h22;
        #1;
        checks++; if (srca !== 32'h11) begin errors++; $display("FAIL fwd_mem_a got=%0h exp=11", srca); end
        checks++; if (srcb !== 32'h11) begin errors++; $display("FAIL fwd_mem_b got=%0h exp=11", srcb); end
        mem_regwrite = 0; #1;
        checks++; if (srca !== 32'h22) begin errors++; $display("FAIL fwd_wb_a got=%0h exp=22", srca); end
        wb_rd = 5'd6; #1;
        checks++; if (srca !== 32'h33 || srcb !== 32'h44) begin errors++; $display("FAIL fwd_none got=%0h/%0h exp=33/44", srca, srcb); end
        mem_regwrite = 1; wb_rd = 5'd0; mem_rd = 5'd0;
        stall = 0; in_valid = 1; rs1 = 5'd0; rs2 = 5'd0; rd1 = 32'h77; rd2 = 32'h88;
        step();
        checks++; if (srca !== 32'h77 || srcb !== 32'h88) begin errors++; $display("FAIL fwd_x0 got=%0h/%0h exp=77/88", srca, srcb); end
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        in_valid = 1; alu_op = 2'b10; funct3 = 3'b110; op5 = 1; rd = 5'd9;
        rs1 = 5'd1; rd1 = 32'haa;
        step();
        stall = 1; flush = 1;
        step();
        checks++; if (ex_valid !== 1'b0 || alu_control !== 4'b0000 || ex_rd !== 5'd0) begin errors++; $display("FAIL flush_bubble got=%0b/%0h/%0h exp=0/0/0", ex_valid, alu_control, ex_rd); end
        flush = 0; stall = 0; funct3 = 3'b100;
        step();
        stall = 1; funct3 = 3'b111; rd = 5'd12; rd1 = 32'hbb;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ex_valid !== 1'b1 || alu_control !== 4'b0100 || ex_rd !== 5'd9 || srca !== 32'haa) begin errors++; $display("FAIL stall_hold_%0d got=%0b/%0h/%0h/%0h exp=1/4/9/aa", i, ex_valid, alu_control, ex_rd, srca); end
        end
        stall = 0;
        step();
        checks++; if (alu_control !== 4'b0010 || ex_rd !== 5'd12) begin errors++; $display("FAIL stall_release got=%0h/%0h exp=2/c", alu_control, ex_rd); end
        in_valid = 0;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin errors++; $display("FAIL load_bubble got=%0b/%0h exp=0/0", ex_valid, ex_rd); end
    endtask

    task automatic test_branch();
        idle_inputs();
        in_valid = 1; alu_op = 2'b01; funct3 = 3'b001; is_branch = 1;
        step();
        zero = 0; #1;
        checks++; if (branch_taken !== 1'b1 || alu_control !== 4'b0001) begin errors++; $display("FAIL bne_taken got=%0b/%0h exp=1/1", branch_taken, alu_control); end
        zero = 1; #1;
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bne_not_taken got=%0b exp=0", branch_taken); end
        funct3 = 3'b000;
        step();
        checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got=%0b exp=1", branch_taken); end
        is_branch = 0;
        step();
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL nonbranch got=%0b exp=0", branch_taken); end
    endtask

    task automatic test_illegal();
        idle_inputs();
        in_valid = 1; alu_op = 2'b10; funct3 = 3'b101; op5 = 1;
        step();
        checks++; if (illegal !== 1'b1 || alu_control !== 4'b0000) begin errors++; $display("FAIL illegal_101 got=%0b/%0h exp=1/0", illegal, alu_control); end
        alu_op = 2'b11; funct3 = 3'b010;
        step();
        checks++; if (illegal !== 1'b1 || alu_control !== 4'b0000) begin errors++; $display("FAIL illegal_op11 got=%0b/%0h exp=1/0", illegal, alu_control); end
        in_valid = 0;
        step();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_bubble got=%0b exp=0", illegal); end
        // reset arriving while stalled
        in_valid = 1; alu_op = 2'b10; funct3 = 3'b011; rd = 5'd20; rs1 = 5'd3; rd1 = 32'h99;
        is_branch = 1; alu_op = 2'b01; funct3 = 3'b001;
        step();
        stall = 1;
        step();
        rst = 1;
        step();
        rst = 0;
        checks++; if (ex_valid !== 1'b0 || alu_control !== 4'b0000 || ex_rd !== 5'd0 || illegal !== 1'b0 || branch_taken !== 1'b0 || srca !== 0 || srcb !== 0) begin
            errors++; $display("FAIL rst_in_stall got=%0b/%0h/%0h/%0b/%0b/%0h/%0h exp=all0", ex_valid, alu_control, ex_rd, illegal, branch_taken, srca, srcb);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_rtype_sub();
        test_decode();
        test_forwarding();
        test_stall_flush();
        test_branch();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have ports (clock and reset first):
 clk  in  1  sole clock; all state updates on rising edge.
 rst  in  1  synchronous, active-high reset.
 in_valid  in  1  decode slot holds an instruction.
 stall  in  1  hold EX register contents.
 flush  in  1  replace EX register with a bubble.
 alu_op  in  2  00 add (ld/st), 01 branch compare, 10 funct-decoded.
 funct3  in  3  instruction funct3.
 funct7b5  in  1  instruction bit 30.
 op5  in  1  opcode bit 5 (1 = R-type).
 is_branch  in  1  instruction is BEQ/BNE.
 alusrc  in  1  1 = srcb from imm.
 rs1, rs2, rd  in  5 each  register addresses.
 rd1, rd2, imm  in  XLEN each  register-file data, sign-extended immediate.
 mem_regwrite, wb_regwrite  in  1 each  downstream writes register.
 mem_rd, wb_rd  in  5 each  downstream destinations.
 mem_result, wb_result  in  XLEN each  downstream values.
 alu_result  in  XLEN  ALU output (unused internally except forwarding-free checks).
 zero  in  1  ALU zero flag.
 ex_valid  out  1  EX register holds a live instruction.
 alu_control  out  4  ALU command.
 srca, srcb  out  XLEN  ALU operands.
 ex_rd  out  5  EX destination.
 illegal  out  1  live EX instruction has unsupported ALU function.
 branch_taken  out  1  resolved taken branch.

Function
REQ-003 SHALL hold one EX register: valid, alu_control, illegal, is_branch, funct3[0], alusrc, rs1, rs2, rd, rd1, rd2, imm.
REQ-004 SHALL decode alu_control combinationally from inputs and register it: alu_op 00 -> 0000; 01 -> 0001; 10 -> by funct3: 000 -> 0001 if op5&funct7b5 else 0000; 010 -> 0101; 100 -> 0100; 110 -> 0011; 111 -> 0010.
REQ-005 SHALL, for alu_op 10 with funct3 001/011/101, or alu_op 11, register alu_control 0000 and illegal=1 (when valid).
REQ-006 SHALL update priority per edge: rst > flush > stall > load.
REQ-007 SHALL on load capture all fields; valid = in_valid; if in_valid=0 load a bubble.
REQ-008 SHALL define a bubble as valid=0, alu_control 0000, illegal 0, is_branch 0, rd 0, data fields 0.
REQ-009 SHALL on stall (no flush) hold every register unchanged.
REQ-010 SHALL on flush load a bubble regardless of stall and in_valid.
REQ-011 SHALL forward srca combinationally: if mem_regwrite & mem_rd==rs1_q & rs1_q!=0 -> mem_result; else if wb_regwrite & wb_rd==rs1_q & rs1_q!=0 -> wb_result; else rd1_q. Same for rs2 operand.
REQ-012 SHALL drive srcb = imm_q if alusrc_q else forwarded rs2 operand.
REQ-013 SHALL drive branch_taken = ex_valid & is_branch_q & (zero XOR funct3_q[0]) combinationally, 0 cycles after operands.
REQ-014 SHALL drive illegal = illegal_q & ex_valid; ex_rd = rd_q.
REQ-015 SHALL give a latency of exactly one clock from capture to EX outputs.

Reset
REQ-016 SHALL on rst=1 at an edge load a bubble; outputs then ex_valid 0, alu_control 0000, ex_rd 0, illegal 0, branch_taken 0, srca/srcb 0 (absent forwarding hits).
REQ-017 SHALL let rst override stall and flush in the same cycle, including mid-stall.

Verification
REQ-018 R-type sub: alu_op 10, funct3 000, op5 1, funct7b5 1, rd1 9, rd2 4 -> next cycle alu_control 0001, srca 9, srcb 4, ex_valid 1.
REQ-019 Forwarding priority: rs1=5, mem_rd=5 mem_result 0x11, wb_rd=5 wb_result 0x22, both regwrite -> srca 0x11; rs1=0 same setup -> srca rd1_q.
REQ-020 Stall+flush same cycle with live EX -> next cycle ex_valid 0, alu_control 0000; stall alone for 3 cycles -> outputs unchanged.
REQ-021 BNE: funct3 001, is_branch, alu_op 01, zero 0 -> branch_taken 1; zero 1 -> 0.
REQ-022 Illegal: alu_op 10, funct3 101 -> illegal 1, alu_control 0000; rst asserted during stall -> all outputs reset values next cycle.
